operand_entry_fsm: RTL and testbench

OPERAND_ENTRY_FSM -- requirements
Module: operand_entry_fsm

---
 rtl/operand_entry_fsm_if.sv | 18 +
 rtl/operand_entry_fsm.sv | 85 ++++++++
 tb/tb_operand_entry_fsm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/operand_entry_fsm_if.sv
// Bus between the operand entry sequencer and its surroundings: button/switch
// inputs from the front panel and the captured operands toward the ALU stage.
interface operand_entry_fsm_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
);
  logic              btn;
  logic              clr;
  logic [DATA_W-1:0] sw;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [OP_W-1:0]   opcode;
  logic              start;
  logic [2:0]        state;

  modport master (output btn, clr, sw, input a, b, opcode, start, state);
  modport slave  (input btn, clr, sw, output a, b, opcode, start, state);
endinterface

// File: rtl/operand_entry_fsm.sv
// Front-panel operand entry: successive button presses capture A, B and the
// opcode from the switches, then fire a one-cycle Start strobe to the ALU.
module operand_entry_fsm #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input logic                clk,
  input logic                rst,
  operand_entry_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  // Kept as a plain vector so the unused encodings 5..7 remain representable.
  logic [2:0]        state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   opcode_q;
  logic              start_q;
  logic              btn_prev;
  logic              press;

  assign press = bus.btn & ~btn_prev;

  // NOTE: every register here is assigned with <= so all updates in this block
  // see the values from before the edge; mixing in = would create order races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      opcode_q <= '0;
      start_q  <= 1'b0;
      // NOTE: resetting to 1 means a button held through reset release reads
      // as "already pressed" and must be released before it counts again.
      btn_prev <= 1'b1;
    end else begin
      btn_prev <= bus.btn;
      start_q  <= 1'b0;
      if (bus.clr) begin
        state_q <= LOAD_A;
      end else begin
        case (state_q)
          LOAD_A: begin
            if (press) begin
              a_q     <= bus.sw;
              state_q <= LOAD_B;
            end
          end
          LOAD_B: begin
            if (press) begin
              b_q     <= bus.sw;
              state_q <= LOAD_OP;
            end
          end
          LOAD_OP: begin
            if (press) begin
              opcode_q <= bus.sw[OP_W-1:0];
              state_q  <= EXEC;
              start_q  <= 1'b1;
            end
          end
          EXEC:    state_q <= SHOW;
          SHOW: begin
            if (press) state_q <= LOAD_A;
          end
          default: state_q <= LOAD_A;
        endcase
      end
    end
  end

  assign bus.state  = state_q;
  assign bus.a      = a_q;
  assign bus.b      = b_q;
  assign bus.opcode = opcode_q;
  assign bus.start  = start_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Scoreboard bench for operand_entry_fsm: the driver queues the expected
// post-edge outputs for every cycle it drives, a monitor compares them.
module tb_operand_entry_fsm;

  localparam int DW = 8;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst;
  int   edges    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct {
    string      name;
    int         cyc;
    logic [2:0] state;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       start;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  operand_entry_fsm_if #(.DATA_W(DW), .OP_W(OW)) bus ();

  operand_entry_fsm #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue what the outputs
  // must read after the following rising edge.
  task automatic step(input logic b_i, input logic c_i, input logic [7:0] sw_i,
                      input string nm, input logic [2:0] st, input logic [7:0] ea,
                      input logic [7:0] eb, input logic [3:0] eo, input logic es);
    exp_t e;
    @(negedge clk);
    bus.btn = b_i;
    bus.clr = c_i;
    bus.sw  = sw_i;
    e.name  = nm;
    e.cyc   = edges + 1;
    e.state = st;
    e.a     = ea;
    e.b     = eb;
    e.op    = eo;
    e.start = es;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #2;
    while (sb.size() > 0 && sb[0].cyc <= edges) begin
      mon_e = sb.pop_front();
      check({mon_e.name, ".state"},  {29'd0, bus.state},  {29'd0, mon_e.state});
      check({mon_e.name, ".a"},      {24'd0, bus.a},      {24'd0, mon_e.a});
      check({mon_e.name, ".b"},      {24'd0, bus.b},      {24'd0, mon_e.b});
      check({mon_e.name, ".opcode"}, {28'd0, bus.opcode}, {28'd0, mon_e.op});
      check({mon_e.name, ".start"},  {31'd0, bus.start},  {31'd0, mon_e.start});
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int wait_n;
    rst     = 1'b1;
    bus.btn = 1'b0;
    bus.clr = 1'b0;
    bus.sw  = '0;

    // Reset values must appear before any clock edge.
    #2;
    check("rst_noclk.state", {29'd0, bus.state}, 32'd0);
    check("rst_noclk.a",     {24'd0, bus.a},     32'd0);
    check("rst_noclk.start", {31'd0, bus.start}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full operation: 3C, 05, opcode 2, one Start cycle, SHOW, back to LOAD_A.
    step(0, 0, 8'h00, "idle",      3'd0, 8'h00, 8'h00, 4'h0, 0);
    step(1, 0, 8'h3C, "press_a",   3'd1, 8'h3C, 8'h00, 4'h0, 0);
    step(0, 0, 8'h05, "rel_a",     3'd1, 8'h3C, 8'h00, 4'h0, 0);
    step(1, 0, 8'h05, "press_b",   3'd2, 8'h3C, 8'h05, 4'h0, 0);
    step(0, 0, 8'h02, "rel_b",     3'd2, 8'h3C, 8'h05, 4'h0, 0);
    step(1, 0, 8'h02, "press_op",  3'd3, 8'h3C, 8'h05, 4'h2, 1);
    step(1, 0, 8'hAA, "exec",      3'd4, 8'h3C, 8'h05, 4'h2, 0);
    step(0, 0, 8'hAA, "show",      3'd4, 8'h3C, 8'h05, 4'h2, 0);
    step(0, 0, 8'h77, "show_sw",   3'd4, 8'h3C, 8'h05, 4'h2, 0);
    step(1, 0, 8'h77, "press_shw", 3'd0, 8'h3C, 8'h05, 4'h2, 0);
    step(0, 0, 8'h77, "rel_shw",   3'd0, 8'h3C, 8'h05, 4'h2, 0);

    // Button held 50 cycles yields exactly one advance.
    step(1, 0, 8'h11, "hold0", 3'd1, 8'h11, 8'h05, 4'h2, 0);
    for (int i = 1; i < 50; i++)
      step(1, 0, 8'h11 + 8'(i), "hold", 3'd1, 8'h11, 8'h05, 4'h2, 0);
    step(0, 0, 8'h22, "hold_rel", 3'd1, 8'h11, 8'h05, 4'h2, 0);
    step(1, 0, 8'h22, "repress",  3'd2, 8'h11, 8'h22, 4'h2, 0);
    step(0, 0, 8'hFF, "rel_rp",   3'd2, 8'h11, 8'h22, 4'h2, 0);

    // Clear wins over a simultaneous press in LOAD_OP; opcode untouched.
    step(1, 1, 8'hFF, "clr_press", 3'd0, 8'h11, 8'h22, 4'h2, 0);
    step(0, 0, 8'hFF, "after_clr", 3'd0, 8'h11, 8'h22, 4'h2, 0);

    // Clear during EXEC: Start still shown for its cycle, then LOAD_A.
    step(1, 0, 8'h44, "c_a",       3'd1, 8'h44, 8'h22, 4'h2, 0);
    step(0, 0, 8'h55, "c_rel_a",   3'd1, 8'h44, 8'h22, 4'h2, 0);
    step(1, 0, 8'h55, "c_b",       3'd2, 8'h44, 8'h55, 4'h2, 0);
    step(0, 0, 8'h09, "c_rel_b",   3'd2, 8'h44, 8'h55, 4'h2, 0);
    step(1, 0, 8'h09, "c_op",      3'd3, 8'h44, 8'h55, 4'h9, 1);
    step(0, 1, 8'h09, "clr_exec",  3'd0, 8'h44, 8'h55, 4'h9, 0);
    step(0, 0, 8'h09, "post_clr",  3'd0, 8'h44, 8'h55, 4'h9, 0);

    // Button held through reset does not count until released and pressed.
    @(negedge clk);
    bus.btn = 1'b1;
    bus.sw  = 8'h5A;
    rst     = 1'b1;
    #1;
    check("rst_async.a", {24'd0, bus.a}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'h5A, "held_rst0", 3'd0, 8'h00, 8'h00, 4'h0, 0);
    step(1, 0, 8'h5A, "held_rst1", 3'd0, 8'h00, 8'h00, 4'h0, 0);
    step(0, 0, 8'h5A, "held_rel",  3'd0, 8'h00, 8'h00, 4'h0, 0);
    step(1, 0, 8'h5A, "held_prs",  3'd1, 8'h5A, 8'h00, 4'h0, 0);

    // Asynchronous reset in the middle of EXEC.
    step(0, 0, 8'h66, "r_rel_a",   3'd1, 8'h5A, 8'h00, 4'h0, 0);
    step(1, 0, 8'h66, "r_b",       3'd2, 8'h5A, 8'h66, 4'h0, 0);
    step(0, 0, 8'h03, "r_rel_b",   3'd2, 8'h5A, 8'h66, 4'h0, 0);
    step(1, 0, 8'h03, "r_op",      3'd3, 8'h5A, 8'h66, 4'h3, 1);
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    check("rst_exec.start",  {31'd0, bus.start},  32'd0);
    check("rst_exec.state",  {29'd0, bus.state},  32'd0);
    check("rst_exec.a",      {24'd0, bus.a},      32'd0);
    check("rst_exec.b",      {24'd0, bus.b},      32'd0);
    check("rst_exec.opcode", {28'd0, bus.opcode}, 32'd0);
    @(negedge clk);
    bus.btn = 1'b0;
    rst     = 1'b0;

    // Illegal encoding returns to LOAD_A after one edge with Start low.
    step(0, 0, 8'h00, "idle2", 3'd0, 8'h00, 8'h00, 4'h0, 0);
    @(posedge clk);
    #3;
    force dut.state_q = 3'd6;
    #1;
    check("illegal.state_forced", {29'd0, bus.state}, 32'd6);
    release dut.state_q;
    check("illegal.start", {31'd0, bus.start}, 32'd0);
    step(0, 0, 8'h00, "illegal_ret", 3'd0, 8'h00, 8'h00, 4'h0, 0);
    step(0, 0, 8'h00, "illegal_idl", 3'd0, 8'h00, 8'h00, 4'h0, 0);

    wait_n = 0;
    while (sb.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    #3;
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
